// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - alucontrol encodings shared with the ALU decoder, FSM state type
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/alu_iter_if.sv
// rtl/alu_iter_if.sv - operand/opcode request and result handshake bundle
interface alu_iter_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alucontrol;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  modport master (
    output in_valid, a, b, alucontrol, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, a, b, alucontrol, out_ready,
    output in_ready, out_valid, result, zero
  );

endinterface

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle ALU datapath; shifts included only with ALU_ITER_BARREL_EN
module alu_comb
  import alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  op_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {31'd0, $signed(a_i) < $signed(b_i)};
`ifdef ALU_ITER_BARREL_EN
      ALU_SLL: result_o = a_i << b_i[4:0];
      ALU_SRL: result_o = a_i >> b_i[4:0];
`endif
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - handshaked ALU with serial shifter; ALU_ITER_BARREL_EN makes every op single-cycle
module alu_iter
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  alu_iter_if.slave   bus
);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] res_q, res_d;
  logic        left_q, left_d;
  logic [31:0] sh_next;
  logic [31:0] comb_res;
  logic        xfer;

  alu_comb u_comb (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .op_i     (bus.alucontrol),
    .result_o (comb_res)
  );

  assign xfer    = bus.in_valid && (state_q == ST_IDLE);
  assign sh_next = left_q ? (sh_q << 1) : (sh_q >> 1);

`ifndef ALU_ITER_BARREL_EN
  logic       is_shift;
  logic [4:0] shamt;
  assign is_shift = (bus.alucontrol == ALU_SLL) || (bus.alucontrol == ALU_SRL);
  assign shamt    = bus.b[4:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    res_d   = res_q;
    left_d  = left_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_DONE;
`ifdef ALU_ITER_BARREL_EN
          res_d = comb_res;
`else
          if (is_shift && (shamt != 5'd0)) begin
            sh_d    = bus.a;
            cnt_d   = shamt;
            left_d  = (bus.alucontrol == ALU_SLL);
            state_d = ST_SHIFT;
          end else if (is_shift) begin
            res_d = bus.a;
          end else begin
            res_d = comb_res;
          end
`endif
        end
      end
      ST_SHIFT: begin
        // Last shift writes straight into the result so DONE lands shamt+1 cycles after transfer
        sh_d  = sh_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          res_d   = sh_next;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      res_q   <= '0;
      left_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      left_q  <= left_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = res_q;
  assign bus.zero      = (res_q == 32'd0);

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed-vector bench for alu_iter; expected latency follows ALU_ITER_BARREL_EN
module tb_alu_iter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_iter_if bus();

  alu_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef ALU_ITER_BARREL_EN
    return 1;
`else
    logic [4:0] s;
    s = b[4:0];
    if ((op == ALU_SLL || op == ALU_SRL) && s != 5'd0) return int'(s) + 1;
    return 1;
`endif
  endfunction

  // hold > 0: keep out_ready low that many cycles in DONE while poking in_valid
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp_res, input int hold);
    int lat;
    logic [31:0] held;
    check_eq({tag, "/in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid   = 1'b1;
    bus.a          = a;
    bus.b          = b;
    bus.alucontrol = op;
    tick;
    bus.in_valid   = 1'b0;
    bus.a          = ~a;
    bus.b          = 32'h0000_0003;
    bus.alucontrol = ALU_ADD;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      tick;
      lat++;
    end
    check_eq({tag, "/latency"}, 32'(lat), 32'(exp_lat(op, b)));
    check_eq({tag, "/result"}, bus.result, exp_res);
    check_eq({tag, "/zero"}, {31'd0, bus.zero}, {31'd0, exp_res == 32'd0});
    held = bus.result;
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      bus.a        = 32'h1111_1111;
      bus.b        = 32'h2222_2222;
      for (int i = 0; i < hold; i++) begin
        tick;
        check_eq({tag, "/bp_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check_eq({tag, "/bp_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check_eq({tag, "/bp_stable"}, bus.result, held);
      end
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq({tag, "/retired"}, {31'd0, bus.out_valid}, 32'd0);
    if (hold > 0) begin
      tick;
      check_eq({tag, "/no_accept_on_retire"}, {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    end
  endtask

  initial begin
    bit seen;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.alucontrol = ALU_ADD;
    tick;
    tick;
    reset = 1'b0;
    check_eq("rst/in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst/out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst/result", bus.result, 32'd0);
    check_eq("rst/zero", {31'd0, bus.zero}, 32'd1);

    run_op("add_wrap_sign", 32'h7FFF_FFFF, 32'd1, ALU_ADD, 32'h8000_0000, 0);
    run_op("add_wrap_zero", 32'hFFFF_FFFF, 32'd1, ALU_ADD, 32'h0000_0000, 0);
    run_op("sub_eq", 32'd5, 32'd5, ALU_SUB, 32'd0, 0);
    run_op("sub_wrap", 32'd0, 32'd1, ALU_SUB, 32'hFFFF_FFFF, 0);
    run_op("slt_neg", 32'hFFFF_FFFF, 32'd1, ALU_SLT, 32'd1, 0);
    run_op("slt_pos", 32'd1, 32'hFFFF_FFFF, ALU_SLT, 32'd0, 0);
    run_op("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, 32'h00F0_00F0, 0);
    run_op("or", 32'hF000_0000, 32'h0000_000F, ALU_OR, 32'hF000_000F, 0);
    run_op("illegal", 32'd5, 32'd3, 3'b011, 32'd0, 0);
    run_op("sll31", 32'h0000_0001, 32'd31, ALU_SLL, 32'h8000_0000, 0);
    run_op("srl4", 32'h8000_0000, 32'd4, ALU_SRL, 32'h0800_0000, 0);
    run_op("sll0", 32'h0000_1234, 32'd0, ALU_SLL, 32'h0000_1234, 0);
    run_op("srl_hi_bits", 32'hF000_0000, 32'hFFFF_FFE1, ALU_SRL, 32'h7800_0000, 0);
    run_op("sll1_drop", 32'h8000_0001, 32'd1, ALU_SLL, 32'h0000_0002, 0);
    run_op("backpressure", 32'd3, 32'd4, ALU_ADD, 32'd7, 3);
    run_op("bp_shift", 32'h0000_00F0, 32'd2, ALU_SRL, 32'h0000_003C, 3);

    bus.in_valid   = 1'b1;
    bus.a          = 32'd1;
    bus.b          = 32'd20;
    bus.alucontrol = ALU_SLL;
    tick;
    bus.in_valid = 1'b0;
    repeat (4) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check_eq("midrst/in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("midrst/out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("midrst/result", bus.result, 32'd0);
    check_eq("midrst/zero", {31'd0, bus.zero}, 32'd1);
    seen = 1'b0;
    repeat (30) begin
      tick;
      if (bus.out_valid) seen = 1'b1;
    end
    check_eq("midrst/no_stale", {31'd0, seen}, 32'd0);
    run_op("after_rst", 32'h0000_0003, 32'd3, ALU_SLL, 32'h0000_0018, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: the operand/opcode bundle is valid.
REQ-004 The block SHALL have the port in_ready, output, 1 bit: the block can accept a bundle.
REQ-005 The block SHALL have the port a, input, 32 bits: operand A.
REQ-006 The block SHALL have the port b, input, 32 bits: operand B; b[4:0] is the shift amount.
REQ-007 The block SHALL have the port alucontrol, input, 3 bits: opcode as produced by the ALU decoder.
REQ-008 The block SHALL have the port out_valid, output, 1 bit: result and zero are valid.
REQ-009 The block SHALL have the port out_ready, input, 1 bit: the consumer accepts the result.
REQ-010 The block SHALL have the port result, output, 32 bits: operation result.
REQ-011 The block SHALL have the port zero, output, 1 bit: result == 0.

Function
REQ-012 The opcode encoding SHALL be: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed, result 0 or 1), 100 sll, 101 srl (logical); 011 is illegal and SHALL yield result 0.
REQ-013 Add and sub SHALL wrap modulo 2^32, with no overflow flag.
REQ-014 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1; a, b and alucontrol SHALL be captured on transfer.
REQ-016 On a non-shift op, IDLE SHALL go to DONE with result registered; latency is 1 cycle (out_valid high on the cycle after transfer).
REQ-017 On sll/srl with shamt=0, IDLE SHALL go to DONE with result=a (latency 1).
REQ-018 On sll/srl with shamt>0, IDLE SHALL go to SHIFT; each SHIFT cycle SHALL shift the working register 1 bit and decrement the counter; when the counter reaches 0, the FSM SHALL go to DONE; out_valid is first high shamt+1 cycles after transfer.
REQ-019 In DONE, out_valid SHALL be 1 and result/zero SHALL be held stable until out_ready=1; DONE+out_ready SHALL go to IDLE.
REQ-020 No new bundle SHALL be accepted in the cycle a result retires; the minimum spacing between transfers is 2 cycles.
REQ-021 in_valid while not in IDLE SHALL be ignored; inputs changing during SHIFT/DONE SHALL NOT affect the result.
REQ-022 zero SHALL be derived from the registered result and be valid whenever out_valid=1.

Reset
REQ-023 On reset=1 at a clock edge, state SHALL be IDLE, in_ready=1, out_valid=0, result=0, zero=1, and the counter SHALL be 0.
REQ-024 A reset asserted during SHIFT or DONE SHALL abort the operation; the pending result SHALL be discarded and never presented.

Configuration
REQ-025 With macro ALU_ITER_BARREL_EN defined, sll/srl SHALL use a single-cycle barrel shifter, SHIFT SHALL be unreachable, and all ops SHALL have latency 1.
REQ-026 Without ALU_ITER_BARREL_EN, shifts SHALL be serial per REQ-018; opcode results SHALL be identical in both builds.

Structure
REQ-027 Package alu_pkg SHALL hold the alucontrol encoding constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL), shared with the ALU decoder, and the FSM state typedef.
REQ-028 The single-cycle ops (add/sub/and/or/slt, plus shifts when barrel is enabled) SHALL live in the combinational sub-module alu_comb; alu_iter SHALL own the FSM, counter, shift register and handshake.

Verification
REQ-029 Add: a=0x7FFFFFFF, b=1, op=010 -> result=0x80000000, zero=0, out_valid 1 cycle after transfer.
REQ-030 Sub/slt: a=5, b=5, op=110 -> result=0, zero=1; a=0xFFFFFFFF, b=1, op=111 -> result=1.
REQ-031 Serial sll: a=0x00000001, b=31, op=100 -> result=0x80000000, out_valid 32 cycles after transfer; srl a=0x80000000, b=4 -> 0x08000000 after 5 cycles.
REQ-032 Backpressure: out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0 throughout; new in_valid ignored; retires on out_ready=1.
REQ-033 Reset mid-shift: sll a=1, b=20, reset at cycle 5 -> next cycle IDLE, out_valid=0, result=0, and no stale result afterwards.
REQ-034 Illegal op 011 -> result=0, zero=1, latency 1; rerun REQ-031 with ALU_ITER_BARREL_EN defined -> latency 1, same results.
